mem_stage: RTL

Memory-access pipeline stage that sits between the execute stage and `wb_stage`. It accepts one instruction at a time over the `es_to_ms` valid/allowin handshake and performs any load or store on the data SRAM request/response interface. It then aligns and extends load data and presents a 70-bit result bus to the write-back stage over the `ms_to_ws` valid/allowin handshake. It also exports hazard and forwarding information for the decode stage.

---
 rtl/mem_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Issues loads/stores on the data SRAM request/response interface, aligns and
// extends load data, and exports hazard/forwarding information to decode.
module mem_stage (
   input  logic          clk,
   input  logic          resetn,
   input  logic          es_to_ms_valid,
   input  logic [105:0]  es_to_ms_bus,
   output logic          ms_allowin,
   input  logic          ws_allowin,
   output logic          ms_to_ws_valid,
   output logic [69:0]   ms_to_ws_bus,
   output logic          ms_write_reg,
   output logic [4:0]    ms_reg_dest,
   output logic          ms_fwd_valid,
   output logic [31:0]   ms_fwd_data,
   output logic          data_sram_req,
   output logic          data_sram_wr,
   output logic [1:0]    data_sram_size,
   output logic [3:0]    data_sram_wstrb,
   output logic [31:0]   data_sram_addr,
   output logic [31:0]   data_sram_wdata,
   input  logic          data_sram_addr_ok,
   input  logic          data_sram_data_ok,
   input  logic [31:0]   data_sram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state;
   logic          ms_valid;
   logic [105:0]  bus;
   logic [31:0]   ld_data;

   logic [3:0]    mem_op;
   logic [31:0]   st_data;
   logic          gr_we;
   logic [4:0]    dest;
   logic [31:0]   alu_result;
   logic [31:0]   pc;

   logic          is_load;
   logic          is_store;
   logic [1:0]    size;
   logic          ms_ready_go;
   logic          accept;
   logic          in_is_mem;
   logic [31:0]   final_result;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;

   assign {mem_op, st_data, gr_we, dest, alu_result, pc} = bus;

   assign in_is_mem = es_to_ms_bus[105:102] inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};

   // Decode the held mem_op into load/store class and access size.
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      size     = 2'd2;
      case (mem_op)
         4'd1:       is_load = 1'b1;
         4'd2, 4'd3: begin is_load = 1'b1; size = 2'd0; end
         4'd4, 4'd5: begin is_load = 1'b1; size = 2'd1; end
         4'd8:       is_store = 1'b1;
         4'd9:       begin is_store = 1'b1; size = 2'd0; end
         4'd10:      begin is_store = 1'b1; size = 2'd1; end
         default:    ;
      endcase
   end

   assign ms_ready_go    = !(is_load || is_store) || (state == S_DONE);
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign accept         = es_to_ms_valid && ms_allowin;

   // Pipeline valid, bus capture, SRAM handshake sequencing and load capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid <= 1'b0;
         bus      <= '0;
         state    <= S_IDLE;
         ld_data  <= '0;
      end else begin
         if (ms_allowin)
            ms_valid <= es_to_ms_valid;
         if (accept)
            bus <= es_to_ms_bus;
         case (state)
            S_IDLE: if (accept && in_is_mem) state <= S_REQ;
            S_REQ:  if (data_sram_addr_ok) state <= S_WAIT;
            S_WAIT: if (data_sram_data_ok) begin
                       ld_data <= data_sram_rdata;
                       state   <= S_DONE;
                    end
            S_DONE: if (ws_allowin) state <= (accept && in_is_mem) ? S_REQ : S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign data_sram_req  = (state == S_REQ);
   assign data_sram_wr   = is_store;
   assign data_sram_size = size;
   assign data_sram_addr = alu_result;

   // Store byte strobes and lane-replicated write data.
   always_comb begin
      data_sram_wstrb = 4'b0000;
      data_sram_wdata = st_data;
      case (mem_op)
         4'd8:  data_sram_wstrb = 4'b1111;
         4'd9:  begin
                   data_sram_wstrb = 4'b0001 << alu_result[1:0];
                   data_sram_wdata = {4{st_data[7:0]}};
                end
         4'd10: begin
                   data_sram_wstrb = 4'b0011 << {alu_result[1], 1'b0};
                   data_sram_wdata = {2{st_data[15:0]}};
                end
         default: ;
      endcase
   end

   // Select the addressed lane of the captured load data and extend it.
   always_comb begin
      case (alu_result[1:0])
         2'd0:    ld_byte = ld_data[7:0];
         2'd1:    ld_byte = ld_data[15:8];
         2'd2:    ld_byte = ld_data[23:16];
         default: ld_byte = ld_data[31:24];
      endcase
      ld_half = alu_result[1] ? ld_data[31:16] : ld_data[15:0];
      case (mem_op)
         4'd1:    final_result = ld_data;
         4'd2:    final_result = {{24{ld_byte[7]}}, ld_byte};
         4'd3:    final_result = {24'd0, ld_byte};
         4'd4:    final_result = {{16{ld_half[15]}}, ld_half};
         4'd5:    final_result = {16'd0, ld_half};
         default: final_result = alu_result;
      endcase
   end

   assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
   assign ms_write_reg = ms_valid && gr_we;
   assign ms_reg_dest  = dest;
   assign ms_fwd_valid = ms_write_reg && ms_ready_go;
   assign ms_fwd_data  = final_result;

endmodule
